// File: rtl/modexp_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : modexp_host_ctrl
// Brief    : Sequences rtMod (R, R^2 mod N) and modInv (nprime0) for ModExp,
//            streams operands word-serially and gathers the result words.
// Revision : 1.0
// ============================================================================
module modexp_host_ctrl #(
  parameter int WIDTH        = 4096,
  parameter int DATA_WIDTH   = 64,
  parameter int NWORDS       = WIDTH / DATA_WIDTH,
  parameter int EXP_COMPLETE = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      message,
  input  logic [WIDTH-1:0]      exponent,
  input  logic [WIDTH-1:0]      modulus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      result,
  output logic [WIDTH-1:0]      op_n,
  output logic                  rt_go,
  output logic                  rt_mode,
  input  logic [WIDTH-1:0]      rt_r,
  input  logic                  rt_done,
  output logic                  inv_go,
  input  logic [DATA_WIDTH-1:0] inv_res,
  input  logic                  inv_valid,
  output logic [DATA_WIDTH-1:0] m_buf,
  output logic [DATA_WIDTH-1:0] e_buf,
  output logic [DATA_WIDTH-1:0] n_buf,
  output logic [DATA_WIDTH-1:0] r_buf,
  output logic [DATA_WIDTH-1:0] t_buf,
  output logic [DATA_WIDTH-1:0] nprime0,
  output logic                  start_input,
  output logic                  start_compute,
  output logic                  get_result,
  input  logic [4:0]            exp_state,
  input  logic [DATA_WIDTH-1:0] res_out
);

  localparam int c_IW = $clog2(NWORDS);
  localparam int c_CW = c_IW + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(NWORDS - 1);

  localparam logic [3:0] c_IDLE     = 4'd0;
  localparam logic [3:0] c_CHECK    = 4'd1;
  localparam logic [3:0] c_CALC_R   = 4'd2;
  localparam logic [3:0] c_CALC_T   = 4'd3;
  localparam logic [3:0] c_CALC_N0  = 4'd4;
  localparam logic [3:0] c_SEND     = 4'd5;
  localparam logic [3:0] c_WAIT_EXP = 4'd6;
  localparam logic [3:0] c_READ     = 4'd7;
  localparam logic [3:0] c_DONE     = 4'd8;
  localparam logic [3:0] c_ERR      = 4'd9;

  logic [3:0]                           r_state;
  logic [3:0]                           w_next;
  logic [c_CW-1:0]                      r_cnt;
  logic [WIDTH-1:0]                     r_m;
  logic [WIDTH-1:0]                     r_e;
  logic [WIDTH-1:0]                     r_n;
  logic [WIDTH-1:0]                     r_r;
  logic [WIDTH-1:0]                     r_t;
  logic [DATA_WIDTH-1:0]                r_np;
  logic [NWORDS-1:0][DATA_WIDTH-1:0]    r_res;
  logic                                 r_rt_go;
  logic                                 r_inv_go;
  logic                                 r_sc;
  logic                                 r_rd_lead;
  logic                                 w_rt_ack;
  logic                                 w_exp_done;
  logic [NWORDS-1:0][DATA_WIDTH-1:0]    w_m_words;
  logic [NWORDS-1:0][DATA_WIDTH-1:0]    w_e_words;
  logic [NWORDS-1:0][DATA_WIDTH-1:0]    w_n_words;
  logic [NWORDS-1:0][DATA_WIDTH-1:0]    w_r_words;
  logic [NWORDS-1:0][DATA_WIDTH-1:0]    w_t_words;

  // A result arriving alongside its own go pulse belongs to no request yet.
  assign w_rt_ack   = rt_done && !r_rt_go;
  assign w_exp_done = (exp_state == 5'(EXP_COMPLETE));

  assign w_m_words = r_m;
  assign w_e_words = r_e;
  assign w_n_words = r_n;
  assign w_r_words = r_r;
  assign w_t_words = r_t;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:     if (start) w_next = c_CHECK;
      c_CHECK:    w_next = r_n[0] ? c_CALC_R : c_ERR;
      c_CALC_R:   if (w_rt_ack) w_next = c_CALC_T;
      c_CALC_T:   if (w_rt_ack) w_next = c_CALC_N0;
      c_CALC_N0:  if (inv_valid) w_next = c_SEND;
      c_SEND:     if (r_cnt == c_LAST) w_next = c_WAIT_EXP;
      c_WAIT_EXP: if (w_exp_done) w_next = c_READ;
      c_READ:     if (!r_rd_lead && (r_cnt == c_LAST)) w_next = c_DONE;
      c_DONE:     w_next = c_IDLE;
      c_ERR:      w_next = c_IDLE;
      default:    w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_m       <= '0;
      r_e       <= '0;
      r_n       <= '0;
      r_r       <= '0;
      r_t       <= '0;
      r_np      <= '0;
      r_res     <= '0;
      r_rt_go   <= 1'b0;
      r_inv_go  <= 1'b0;
      r_sc      <= 1'b0;
      r_rd_lead <= 1'b0;
    end else begin
      r_rt_go  <= ((r_state == c_CHECK) && r_n[0]) || ((r_state == c_CALC_R) && w_rt_ack);
      r_inv_go <= (r_state == c_CALC_T) && w_rt_ack;
      r_sc     <= (r_state == c_SEND) && (r_cnt == c_LAST);
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_m <= message;
            r_e <= exponent;
            r_n <= modulus;
          end
        end
        c_CHECK:   if (!r_n[0]) r_res <= '0;
        c_CALC_R:  if (w_rt_ack) r_r <= rt_r;
        c_CALC_T:  if (w_rt_ack) r_t <= rt_r;
        c_CALC_N0: begin
          if (inv_valid) begin
            r_np  <= inv_res;
            r_cnt <= '0;
          end
        end
        c_SEND:    r_cnt <= r_cnt + 1'b1;
        c_WAIT_EXP: begin
          if (w_exp_done) begin
            r_cnt     <= '0;
            r_rd_lead <= 1'b1;
          end
        end
        c_READ: begin
          // ModExp needs one cycle after get_result before word 0 is valid.
          if (r_rd_lead) begin
            r_rd_lead <= 1'b0;
          end else begin
            r_res[r_cnt[c_IW-1:0]] <= res_out;
            r_cnt                  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    rt_mode     = 1'b0;
    start_input = 1'b0;
    get_result  = 1'b0;
    m_buf       = '0;
    e_buf       = '0;
    n_buf       = '0;
    r_buf       = '0;
    t_buf       = '0;
    case (r_state)
      c_CHECK, c_CALC_R, c_CALC_N0, c_WAIT_EXP: busy = 1'b1;
      c_CALC_T: begin
        busy    = 1'b1;
        rt_mode = 1'b1;
      end
      c_SEND: begin
        busy        = 1'b1;
        start_input = 1'b1;
        m_buf       = w_m_words[r_cnt[c_IW-1:0]];
        e_buf       = w_e_words[r_cnt[c_IW-1:0]];
        n_buf       = w_n_words[r_cnt[c_IW-1:0]];
        r_buf       = w_r_words[r_cnt[c_IW-1:0]];
        t_buf       = w_t_words[r_cnt[c_IW-1:0]];
      end
      c_READ: begin
        busy       = 1'b1;
        get_result = 1'b1;
      end
      c_DONE: done = 1'b1;
      c_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign result        = r_res;
  assign op_n          = r_n;
  assign nprime0       = r_np;
  assign rt_go         = r_rt_go;
  assign inv_go        = r_inv_go;
  assign start_compute = r_sc;

endmodule
`default_nettype wire

// File: tb/tb_modexp_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_modexp_host_ctrl
// Brief    : Stubbed rtMod/modInv/ModExp environment with a modular-arithmetic
//            reference for modexp_host_ctrl.
// Revision : 1.0
// ============================================================================
module tb_modexp_host_ctrl;

  localparam int W  = 4096;
  localparam int DW = 64;
  localparam int NW = W / DW;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  message, exponent, modulus;
  logic          busy, done, err;
  logic [W-1:0]  result, op_n;
  logic          rt_go, rt_mode;
  logic [W-1:0]  rt_r;
  logic          rt_done;
  logic          inv_go;
  logic [DW-1:0] inv_res;
  logic          inv_valid;
  logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
  logic          start_input, start_compute, get_result;
  logic [4:0]    exp_state;
  logic [DW-1:0] res_out;

  int n_cmp = 0;
  int n_fail = 0;

  modexp_host_ctrl #(.WIDTH(W), .DATA_WIDTH(DW), .NWORDS(NW), .EXP_COMPLETE(9)) dut (
    .clk(clk), .reset(reset), .start(start),
    .message(message), .exponent(exponent), .modulus(modulus),
    .busy(busy), .done(done), .err(err), .result(result), .op_n(op_n),
    .rt_go(rt_go), .rt_mode(rt_mode), .rt_r(rt_r), .rt_done(rt_done),
    .inv_go(inv_go), .inv_res(inv_res), .inv_valid(inv_valid),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
    .nprime0(nprime0), .start_input(start_input), .start_compute(start_compute),
    .get_result(get_result), .exp_state(exp_state), .res_out(res_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] powmod(input logic [63:0] b_in, input logic [63:0] e_in,
                                         input logic [63:0] n);
    logic [63:0] b, e, r;
    if (n == 0) return 64'd0;
    b = b_in % n;
    e = e_in;
    r = 64'd1 % n;
    while (e != 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Stub configuration, written only by the main sequence
  logic [W-1:0]  R1, R2;
  logic [DW-1:0] INVV;
  bit            spur_en;
  bit            res_mode;

  // rtMod stub: answers a random number of cycles after rt_go
  int rtgo_cnt = 0;
  int mode_hist = 0;
  initial begin
    int  pend, wt;
    logic mq;
    pend = 0; wt = 0; mq = 1'b0;
    rt_done = 1'b0; rt_r = '0;
    forever begin
      @(negedge clk);
      rt_done = 1'b0;
      rt_r = '0;
      if (reset) pend = 0;
      else begin
        if (pend != 0) begin
          if (wt == 0) begin
            rt_done = 1'b1; rt_r = mq ? R2 : R1; pend = 0;
          end else wt--;
        end else if (spur_en && $urandom_range(0, 4) == 0) begin
          rt_done = 1'b1; rt_r = ~R1;
        end
        if (rt_go) begin
          rtgo_cnt++;
          mode_hist = (mode_hist << 1) | int'(rt_mode);
          mq = rt_mode; pend = 1; wt = int'($urandom_range(0, 3));
        end
      end
    end
  end

  // modInv stub
  int invgo_cnt = 0;
  initial begin
    int pend, wt;
    pend = 0; wt = 0;
    inv_valid = 1'b0; inv_res = '0;
    forever begin
      @(negedge clk);
      inv_valid = 1'b0;
      inv_res = '0;
      if (reset) pend = 0;
      else begin
        if (pend != 0) begin
          if (wt == 0) begin
            inv_valid = 1'b1; inv_res = INVV; pend = 0;
          end else wt--;
        end else if (spur_en && !inv_go && $urandom_range(0, 4) == 0) begin
          inv_valid = 1'b1; inv_res = ~INVV;
        end
        if (inv_go) begin
          invgo_cnt++; pend = 1; wt = int'($urandom_range(0, 3));
        end
      end
    end
  end

  // ModExp stub: collects streamed words, computes, then serves result words
  logic [W-1:0]            s_m, s_e, s_n, s_r, s_t;
  logic [DW-1:0]           np_seen;
  logic [NW-1:0][DW-1:0]   ex_words;
  int si_cnt = 0;
  int sc_cnt = 0;
  initial begin
    int widx, wt, gidx;
    bit computing, gseen;
    widx = 0; wt = 0; gidx = 0; computing = 0; gseen = 0;
    s_m = '0; s_e = '0; s_n = '0; s_r = '0; s_t = '0; np_seen = '0; ex_words = '0;
    exp_state = 5'd0; res_out = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        widx = 0; computing = 0; gseen = 0; gidx = 0; exp_state = 5'd0; res_out = '0;
      end else begin
        if (start_input) begin
          if (widx < NW) begin
            s_m[widx*DW +: DW] = m_buf; s_e[widx*DW +: DW] = e_buf;
            s_n[widx*DW +: DW] = n_buf; s_r[widx*DW +: DW] = r_buf;
            s_t[widx*DW +: DW] = t_buf;
          end
          widx++; si_cnt++;
        end else widx = 0;
        if (start_compute) begin
          sc_cnt++; np_seen = nprime0; computing = 1; exp_state = 5'd0;
          wt = int'($urandom_range(0, 5));
          for (int j = 0; j < NW; j++) ex_words[j] = res_mode ? DW'(j + 1) : '0;
          if (!res_mode) ex_words[0] = powmod(s_m[63:0], s_e[63:0], s_n[63:0]);
        end else if (computing) begin
          if (wt == 0) begin exp_state = 5'd9; computing = 0; end
          else wt--;
        end
        if (get_result) begin
          exp_state = 5'd0;
          if (gseen) begin
            if (gidx < NW) res_out = ex_words[gidx];
            gidx++;
          end
          gseen = 1;
        end else begin
          gseen = 0; gidx = 0;
        end
      end
    end
  end

  int done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                        input bit inject, output int lat, output bit busy1);
    bit injected, ok;
    injected = 0; ok = 0; lat = 0; busy1 = 0;
    @(negedge clk);
    message = m; exponent = e; modulus = n; start = 1'b1;
    for (int i = 1; i <= 4000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        busy1 = busy;
        message = rand_wide(); exponent = rand_wide(); modulus = rand_wide();
      end
      if (inject && !injected && rt_go && rt_mode) begin
        start = 1'b1; injected = 1;
      end
      if (done) begin lat = i; ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL op_timeout: done=0 after 4000 cycles, required done=1");
    end
  endtask

  task automatic check_full(input string tag, input logic [W-1:0] m, input logic [W-1:0] e,
                            input logic [W-1:0] n, input logic [W-1:0] exp_res);
    n_cmp++;
    if ({s_m, s_e, s_n} !== {m, e, n}) begin
      n_fail++;
      $display("FAIL %s stream_men: m0=%h e0=%h n0=%h, required %h %h %h", tag,
               s_m[63:0], s_e[63:0], s_n[63:0], m[63:0], e[63:0], n[63:0]);
    end
    n_cmp++;
    if ({s_r, s_t} !== {R1, R2}) begin
      n_fail++;
      $display("FAIL %s stream_rt: r0=%h t0=%h, required %h %h", tag,
               s_r[63:0], s_t[63:0], R1[63:0], R2[63:0]);
    end
    n_cmp++;
    if (np_seen !== INVV || nprime0 !== INVV) begin
      n_fail++;
      $display("FAIL %s nprime0: got %h, required %h", tag, np_seen, INVV);
    end
    n_cmp++;
    if (result !== exp_res || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: got %h err=%b busy=%b, required %h err=0 busy=0", tag,
               result[63:0], err, busy, exp_res[63:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    message = '0; exponent = '0; modulus = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, rt_go, rt_mode, inv_go, start_input, start_compute, get_result} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 0",
               {busy, done, err, rt_go, rt_mode, inv_go, start_input, start_compute, get_result});
    end
    n_cmp++;
    if (result !== '0 || op_n !== '0 || nprime0 !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: result=%h op_n=%h np=%h, required 0", result[63:0], op_n[63:0], nprime0);
    end
    n_cmp++;
    if ({m_buf, e_buf, n_buf, r_buf, t_buf} !== '0) begin
      n_fail++;
      $display("FAIL reset_bufs: m=%h e=%h, required 0", m_buf, e_buf);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, si0, sc0, rt0, inv0;
    bit b1;
    R1 = rand_wide(); R2 = rand_wide(); INVV = 64'hA5A5A5A5A5A5A5A5;
    spur_en = 0; res_mode = 0;
    si0 = si_cnt; sc0 = sc_cnt; rt0 = rtgo_cnt; inv0 = invgo_cnt;
    run_op(W'(8), W'(13), W'(77), 0, lat, b1);
    n_cmp++;
    if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", b1); end
    n_cmp++;
    if (si_cnt - si0 != NW) begin
      n_fail++; $display("FAIL basic_si_cycles: got %0d, required %0d", si_cnt - si0, NW);
    end
    n_cmp++;
    if (sc_cnt - sc0 != 1) begin
      n_fail++; $display("FAIL basic_start_compute: got %0d pulses, required 1", sc_cnt - sc0);
    end
    n_cmp++;
    if (rtgo_cnt - rt0 != 2 || (mode_hist & 3) != 1 || invgo_cnt - inv0 != 1) begin
      n_fail++;
      $display("FAIL basic_gos: rt_go=%0d modes=%0d inv_go=%0d, required 2 1 1",
               rtgo_cnt - rt0, mode_hist & 3, invgo_cnt - inv0);
    end
    check_full("basic", W'(8), W'(13), W'(77), W'(50));
  endtask

  task automatic test_random();
    int lat;
    bit b1;
    logic [W-1:0] m, e, n;
    spur_en = 1; res_mode = 0;
    for (int k = 0; k < 4; k++) begin
      R1 = rand_wide(); R2 = rand_wide(); INVV = {$urandom, $urandom};
      m = W'($urandom); e = W'($urandom); n = W'($urandom | 32'd3);
      run_op(m, e, n, 0, lat, b1);
      check_full("random", m, e, n, W'(powmod(m[63:0], e[63:0], n[63:0])));
    end
    spur_en = 0;
  endtask

  task automatic test_even_modulus();
    int lat, rt0, inv0, d0;
    bit b1;
    logic [W-1:0] n;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? (rand_wide() & ~W'(1)) : '0;
      rt0 = rtgo_cnt; inv0 = invgo_cnt; d0 = done_cnt;
      run_op(rand_wide(), rand_wide(), n, 0, lat, b1);
      n_cmp++;
      if (lat != 2 || err !== 1'b1 || result !== '0) begin
        n_fail++;
        $display("FAIL even_mod: lat=%0d err=%b result=%h, required lat=2 err=1 result=0",
                 lat, err, result[63:0]);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (rtgo_cnt != rt0 || invgo_cnt != inv0 || done_cnt - d0 != 1) begin
        n_fail++;
        $display("FAIL even_gos: rt_go=%0d inv_go=%0d done=%0d, required 0 0 1",
                 rtgo_cnt - rt0, invgo_cnt - inv0, done_cnt - d0);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, d0;
    bit b1;
    logic [W-1:0] m, e, n;
    R1 = rand_wide(); R2 = rand_wide(); INVV = {$urandom, $urandom};
    m = W'($urandom); e = W'($urandom); n = W'($urandom | 32'd3);
    d0 = done_cnt;
    run_op(m, e, n, 1, lat, b1);
    check_full("busy_start", m, e, n, W'(powmod(m[63:0], e[63:0], n[63:0])));
    repeat (30) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_done: done pulses=%0d busy=%b, required 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid_send();
    int k, lat;
    bit hit, b1;
    logic [W-1:0] m, e, n;
    m = rand_wide(); e = rand_wide(); n = rand_wide() | W'(1);
    k = 0; hit = 0;
    @(negedge clk);
    message = m; exponent = e; modulus = n; start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (start_input) begin
        if (k == 20) begin hit = 1; break; end
        k++;
      end
    end
    n_cmp++;
    if (!hit || m_buf !== m[20*DW +: DW] || e_buf !== e[20*DW +: DW]) begin
      n_fail++;
      $display("FAIL word20: hit=%b m_buf=%h e_buf=%h, required %h %h", hit, m_buf, e_buf,
               m[20*DW +: DW], e[20*DW +: DW]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, err, rt_go, rt_mode, inv_go, start_input, start_compute, get_result} !== 9'b0 ||
        {m_buf, e_buf, n_buf, r_buf, t_buf, nprime0} !== '0 || result !== '0 || op_n !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_send: busy=%b si=%b m_buf=%h op_n=%h, required all 0",
               busy, start_input, m_buf, op_n[63:0]);
    end
    reset = 1'b0;
    R1 = rand_wide(); R2 = rand_wide(); INVV = {$urandom, $urandom};
    m = W'($urandom); e = W'($urandom); n = W'($urandom | 32'd3);
    run_op(m, e, n, 0, lat, b1);
    check_full("after_reset", m, e, n, W'(powmod(m[63:0], e[63:0], n[63:0])));
  endtask

  task automatic test_result_pattern();
    int lat, d0;
    bit b1;
    logic [W-1:0] exp_res;
    res_mode = 1;
    for (int j = 0; j < NW; j++) exp_res[j*DW +: DW] = DW'(j + 1);
    run_op(rand_wide(), rand_wide(), rand_wide() | W'(1), 0, lat, b1);
    n_cmp++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL pattern: w0=%h w63=%h, required %h %h", result[63:0],
               result[W-1 -: DW], exp_res[63:0], exp_res[W-1 -: DW]);
    end
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      message = rand_wide(); modulus = rand_wide();
    end
    n_cmp++;
    if (result !== exp_res || busy !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL hold: w0=%h busy=%b extra done=%0d, required %h 0 0", result[63:0], busy,
               done_cnt - d0, exp_res[63:0]);
    end
    res_mode = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    message = '0; exponent = '0; modulus = '0;
    R1 = '0; R2 = '0; INVV = '0; spur_en = 0; res_mode = 0;
    test_reset();
    test_basic();
    test_random();
    test_even_modulus();
    test_start_while_busy();
    test_reset_mid_send();
    test_result_pattern();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
